// File: rtl/display_frame_decoder.sv
// display_frame_decoder
//   Snoops the multiplexed, active-low 7-segment display bus and decodes it
//   back into the shown values: status (capacity / empty slot) or mm:ss time.
//   Each digit scan is collected into a frame, validated, then committed to
//   registered outputs with a one-cycle frame_valid strobe. A frame that is
//   discarded gives a one-cycle frame_error strobe instead.
//
//   Optional feature macro: DECODER_STABLE_EN
//     defined   -> a passing frame commits only if it matches the previous
//                  passing frame, so two identical frames in a row are needed
//     undefined -> every passing frame commits immediately
//
// Ports
//   clk_500Hz   in   scan clock shared with the display driver (rising edge)
//   reset       in   synchronous, active-low
//   seg[6:0]    in   {a,b,c,d,e,f,g}, 0 = lit
//   anode[3:0]  in   active-low one-hot digit enable, 1111 = idle
//   colon       in   1 = status mode, 0 = time mode
//   mode        out  0 = status, 1 = time
//   capacity    out  decoded capacity (status mode)
//   empty_slot  out  decoded empty slot (status mode)
//   minutes     out  decoded minutes (time mode)
//   seconds     out  decoded seconds (time mode)
//   frame_valid out  one-cycle pulse when outputs update
//   frame_error out  one-cycle pulse when a frame is discarded
//   err_count   out  saturating count of frame_error pulses
module display_frame_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk_500Hz,
  input  logic             reset,
  input  logic [6:0]       seg,
  input  logic [3:0]       anode,
  input  logic             colon,
  output logic             mode,
  output logic [2:0]       capacity,
  output logic [1:0]       empty_slot,
  output logic [5:0]       minutes,
  output logic [5:0]       seconds,
  output logic             frame_valid,
  output logic             frame_error,
  output logic [ERR_W-1:0] err_count
);

  // Digit codes: 0..9 numeric, BLANK, ILLEGAL
  localparam logic [3:0] BLANK   = 4'd10;
  localparam logic [3:0] ILLEGAL = 4'd15;

  typedef enum logic [1:0] {WAIT0, GOT0, GOT1, GOT2} state_t;

  state_t state, state_next;

  logic [3:0] seg_code;
  logic       seg_ok;
  logic [1:0] an_idx;
  logic       an_digit, an_idle, an_bad;
  logic [1:0] exp_idx;
  logic       in_frame, hit, bad, restart, advance;
  logic       load_d0, load_d1, load_d2, check;

  logic [3:0] d0_q, d1_q, d2_q;
  logic       colon_q;

  logic [6:0] min_sum, sec_sum;
  logic       status_ok, time_ok, pass, commit, err_now;

  // Segment pattern decode
  always_comb begin
    seg_code = ILLEGAL;
    case (seg)
      7'b0000001: seg_code = 4'd0;
      7'b1001111: seg_code = 4'd1;
      7'b0010010: seg_code = 4'd2;
      7'b0000110: seg_code = 4'd3;
      7'b1001100: seg_code = 4'd4;
      7'b0100100: seg_code = 4'd5;
      7'b0100000: seg_code = 4'd6;
      7'b0001111: seg_code = 4'd7;
      7'b0000000: seg_code = 4'd8;
      7'b0000100: seg_code = 4'd9;
      7'b1111111: seg_code = BLANK;
      default:    seg_code = ILLEGAL;
    endcase
  end

  assign seg_ok = (seg_code != ILLEGAL);

  // Anode decode
  always_comb begin
    an_idx   = '0;
    an_digit = 1'b0;
    an_idle  = 1'b0;
    an_bad   = 1'b0;
    case (anode)
      4'b1110: begin an_digit = 1'b1; an_idx = 2'd0; end
      4'b1101: begin an_digit = 1'b1; an_idx = 2'd1; end
      4'b1011: begin an_digit = 1'b1; an_idx = 2'd2; end
      4'b0111: begin an_digit = 1'b1; an_idx = 2'd3; end
      4'b1111: an_idle = 1'b1;
      default: an_bad  = 1'b1;
    endcase
  end

  // Sample classification shared by the next-state and output processes.
  // In WAIT0 only digit0 matters; any other digit is ignored silently.
  always_comb begin
    case (state)
      WAIT0:   exp_idx = 2'd0;
      GOT0:    exp_idx = 2'd1;
      GOT1:    exp_idx = 2'd2;
      default: exp_idx = 2'd3;
    endcase
  end

  assign in_frame = (state != WAIT0);
  assign hit      = an_digit && (an_idx == exp_idx);
  assign bad      = an_bad
                 || (hit && (!seg_ok || (in_frame && (colon != colon_q))))
                 || (an_digit && in_frame && !hit);
  // Out-of-order digit0 is still an error, but also starts a fresh frame
  assign restart  = an_digit && in_frame && (an_idx == 2'd0) && seg_ok;
  assign advance  = hit && !bad;

  // State register
  always_ff @(posedge clk_500Hz) begin
    if (!reset) state <= WAIT0;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (an_idle)      state_next = WAIT0;
    else if (restart) state_next = GOT0;
    else if (bad)     state_next = WAIT0;
    else if (advance) begin
      case (state)
        WAIT0:   state_next = GOT0;
        GOT0:    state_next = GOT1;
        GOT1:    state_next = GOT2;
        default: state_next = WAIT0;
      endcase
    end
  end

  // Output / control strobes
  always_comb begin
    load_d0 = 1'b0;
    load_d1 = 1'b0;
    load_d2 = 1'b0;
    check   = 1'b0;
    if (restart) load_d0 = 1'b1;
    else if (advance) begin
      case (state)
        WAIT0:   load_d0 = 1'b1;
        GOT0:    load_d1 = 1'b1;
        GOT1:    load_d2 = 1'b1;
        default: check   = 1'b1;
      endcase
    end
  end

  // Commit check; digit3 is the sample currently on the bus
  assign min_sum = ({3'b000, d0_q} * 7'd10) + {3'b000, d1_q};
  assign sec_sum = ({3'b000, d2_q} * 7'd10) + {3'b000, seg_code};

  assign status_ok = (d0_q < 4'd8) && (d1_q == BLANK) && (d2_q < 4'd4)
                  && (seg_code == BLANK);
  assign time_ok   = (d0_q < 4'd10) && (d1_q < 4'd10) && (d2_q < 4'd10)
                  && (seg_code < 4'd10) && (min_sum <= 7'd63)
                  && (sec_sum <= 7'd63);
  assign pass      = check && (colon_q ? status_ok : time_ok);
  assign err_now   = bad || (check && !pass);

`ifdef DECODER_STABLE_EN
  logic [16:0] frame_key, cand_key;
  logic        cand_valid;

  assign frame_key = {~colon_q, d0_q, d1_q, d2_q, seg_code};
  assign commit    = pass && cand_valid && (cand_key == frame_key);

  // Candidate holds the last passing frame; any error forgets it
  always_ff @(posedge clk_500Hz) begin
    if (!reset) begin
      cand_valid <= 1'b0;
      cand_key   <= '0;
    end else if (err_now) begin
      cand_valid <= 1'b0;
    end else if (pass) begin
      cand_valid <= 1'b1;
      cand_key   <= frame_key;
    end
  end
`else
  assign commit = pass;
`endif

  // Capture and output registers
  always_ff @(posedge clk_500Hz) begin
    if (!reset) begin
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      colon_q     <= 1'b0;
      mode        <= 1'b0;
      capacity    <= '0;
      empty_slot  <= '0;
      minutes     <= '0;
      seconds     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= commit;
      frame_error <= err_now;
      if (load_d0) begin
        d0_q    <= seg_code;
        colon_q <= colon;
      end
      if (load_d1) d1_q <= seg_code;
      if (load_d2) d2_q <= seg_code;
      if (commit) begin
        mode <= ~colon_q;
        if (colon_q) begin
          capacity   <= d0_q[2:0];
          empty_slot <= d2_q[1:0];
        end else begin
          minutes <= min_sum[5:0];
          seconds <= sec_sum[5:0];
        end
      end
      if (err_now && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_display_frame_decoder.sv
module tb_display_frame_decoder;

  localparam int EW = 3;

  logic          clk_500Hz = 1'b0;
  logic          reset;
  logic [6:0]    seg;
  logic [3:0]    anode;
  logic          colon;
  logic          mode;
  logic [2:0]    capacity;
  logic [1:0]    empty_slot;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic          frame_valid;
  logic          frame_error;
  logic [EW-1:0] err_count;

  always #5 clk_500Hz = ~clk_500Hz;

  display_frame_decoder #(.ERR_W(EW)) dut (
    .clk_500Hz  (clk_500Hz),
    .reset      (reset),
    .seg        (seg),
    .anode      (anode),
    .colon      (colon),
    .mode       (mode),
    .capacity   (capacity),
    .empty_slot (empty_slot),
    .minutes    (minutes),
    .seconds    (seconds),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .err_count  (err_count)
  );

  // index 0..9 = digits, 10 = blank
  logic [6:0] seg_tab [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b1111111};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_BAD = 7'b1111110;
  localparam logic [3:0] AN_IDLE = 4'b1111;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame is the list of digit values collected so far
  int q[$];
  int qcol;
  int e_mode, e_cap, e_empty, e_min, e_sec, e_valid, e_err, e_cnt;
  bit c_valid;
  int c_key[5];

  function automatic int seg_digit(logic [6:0] s);
    for (int i = 0; i < 11; i++) if (s == seg_tab[i]) return i;
    return -1;
  endfunction

  function automatic int an_digit(logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a == an_tab[i]) return i;
    if (a == AN_IDLE) return 4;
    return -1;
  endfunction

  task automatic flag_error();
    e_err = 1;
    if (e_cnt < (1 << EW) - 1) e_cnt++;
    c_valid = 0;
  endtask

  task automatic model_eval();
    bit ok, do_commit;
    if (qcol != 0)
      ok = q[0] <= 7 && q[1] == 10 && q[2] <= 3 && q[3] == 10;
    else
      ok = q[0] <= 9 && q[1] <= 9 && q[2] <= 9 && q[3] <= 9 &&
           q[0] * 10 + q[1] <= 63 && q[2] * 10 + q[3] <= 63;
    if (!ok) begin
      flag_error();
      return;
    end
`ifdef DECODER_STABLE_EN
    do_commit = c_valid && c_key[0] == (qcol == 0 ? 1 : 0) && c_key[1] == q[0] &&
                c_key[2] == q[1] && c_key[3] == q[2] && c_key[4] == q[3];
    c_valid = 1;
    c_key[0] = (qcol == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) c_key[i+1] = q[i];
`else
    do_commit = 1;
`endif
    if (do_commit) begin
      e_valid = 1;
      e_mode  = (qcol == 0) ? 1 : 0;
      if (qcol != 0) begin
        e_cap   = q[0];
        e_empty = q[2];
      end else begin
        e_min = q[0] * 10 + q[1];
        e_sec = q[2] * 10 + q[3];
      end
    end
  endtask

  task automatic model_sample(logic [3:0] an, logic [6:0] sg, logic cl, logic rst);
    int a, d;
    e_valid = 0;
    e_err   = 0;
    if (!rst) begin
      e_mode = 0; e_cap = 0; e_empty = 0; e_min = 0; e_sec = 0; e_cnt = 0;
      q.delete();
      c_valid = 0;
      return;
    end
    a = an_digit(an);
    d = seg_digit(sg);
    if (a == 4) q.delete();
    else if (a < 0) begin
      flag_error();
      q.delete();
    end else if (q.size() == 0) begin
      if (a == 0) begin
        if (d < 0) flag_error();
        else begin q.push_back(d); qcol = cl; end
      end
    end else if (a != q.size()) begin
      flag_error();
      q.delete();
      if (a == 0 && d >= 0) begin q.push_back(d); qcol = cl; end
    end else if (d < 0 || cl != qcol[0]) begin
      flag_error();
      q.delete();
    end else begin
      q.push_back(d);
      if (q.size() == 4) begin
        model_eval();
        q.delete();
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(logic [3:0] an, logic [6:0] sg, logic cl, logic rst);
    @(negedge clk_500Hz);
    anode = an; seg = sg; colon = cl; reset = rst;
    model_sample(an, sg, cl, rst);
    @(posedge clk_500Hz);
    #1;
    chk("frame_valid", 32'(frame_valid), e_valid);
    chk("frame_error", 32'(frame_error), e_err);
    chk("mode",        32'(mode),        e_mode);
    chk("capacity",    32'(capacity),    e_cap);
    chk("empty_slot",  32'(empty_slot),  e_empty);
    chk("minutes",     32'(minutes),     e_min);
    chk("seconds",     32'(seconds),     e_sec);
    chk("err_count",   32'(err_count),   e_cnt);
  endtask

  task automatic digit(int idx, int val, logic cl);
    step(an_tab[idx], seg_tab[val], cl, 1'b1);
  endtask

  task automatic frame(logic cl, int d0, int d1, int d2, int d3);
    digit(0, d0, cl); digit(1, d1, cl); digit(2, d2, cl); digit(3, d3, cl);
  endtask

  task automatic idle();
    step(AN_IDLE, seg_tab[10], 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] an_s [4];
    logic [6:0] sg_s [4];
    logic       cl_s [4];
    logic       rs_s [4];
    int         d [4];
    int         pd [4];
    logic       c, pc;
    int         k;

    pc = 1'b0;
    for (int i = 0; i < 4; i++) pd[i] = 0;

    // reset state
    step(AN_IDLE, seg_tab[10], 1'b1, 1'b0);
    step(AN_IDLE, seg_tab[10], 1'b1, 1'b0);
    idle();

    // status frame 5, blank, 2, blank
    frame(1'b1, 5, 10, 2, 10);
`ifndef DECODER_STABLE_EN
    chk("status_pulse", 32'(frame_valid), 1);
    chk("status_cap",   32'(capacity),    5);
    chk("status_empty", 32'(empty_slot),  2);
    chk("status_mode",  32'(mode),        0);
`endif

    // time 12:34, then 64:00 rejected
    frame(1'b0, 1, 2, 3, 4);
`ifndef DECODER_STABLE_EN
    chk("time_min",  32'(minutes), 12);
    chk("time_sec",  32'(seconds), 34);
    chk("time_mode", 32'(mode),    1);
`endif
    frame(1'b0, 6, 4, 0, 0);
    chk("over63_err", 32'(frame_error), 1);
    chk("over63_cnt", 32'(err_count),   1);

    // illegal seg on digit2, then a clean 05:59
    digit(0, 0, 1'b0); digit(1, 5, 1'b0);
    step(an_tab[2], SEG_BAD, 1'b0, 1'b1);
    chk("badseg_err", 32'(frame_error), 1);
    digit(3, 9, 1'b0);
    frame(1'b0, 0, 5, 5, 9);

    // digit0 then digit2; then a repeated digit0 restarting the frame
    digit(0, 1, 1'b0); digit(2, 1, 1'b0);
    chk("skip_err", 32'(frame_error), 1);
    digit(0, 7, 1'b0); digit(0, 2, 1'b0);
    chk("restart_err", 32'(frame_error), 1);
    digit(1, 3, 1'b0); digit(2, 4, 1'b0); digit(3, 5, 1'b0);
`ifndef DECODER_STABLE_EN
    chk("restart_min", 32'(minutes), 23);
    chk("restart_sec", 32'(seconds), 45);
`endif

    // colon change mid-frame
    digit(0, 1, 1'b0); digit(1, 1, 1'b1);
    chk("colon_err", 32'(frame_error), 1);

    // reset after digit1, trailing digits, then a normal frame
    digit(0, 4, 1'b0); digit(1, 5, 1'b0);
    step(an_tab[2], seg_tab[1], 1'b0, 1'b0);
    chk("rst_min", 32'(minutes),   0);
    chk("rst_cnt", 32'(err_count), 0);
    digit(2, 1, 1'b0); digit(3, 0, 1'b0);
    frame(1'b0, 4, 5, 1, 0);

    // stability sequence: 12:34, 12:35, 12:35
    frame(1'b0, 1, 2, 3, 4);
    frame(1'b0, 1, 2, 3, 5);
`ifdef DECODER_STABLE_EN
    chk("stable_hold", 32'(frame_valid), 0);
`endif
    frame(1'b0, 1, 2, 3, 5);
    chk("stable_pulse", 32'(frame_valid), 1);
    chk("stable_sec",   32'(seconds),     35);

    // randomized frames with occasional corruption
    for (int f = 0; f < 400; f++) begin
      if (f > 0 && $urandom_range(0, 2) == 0) begin
        c = pc;
        for (int i = 0; i < 4; i++) d[i] = pd[i];
      end else begin
        c = 1'($urandom_range(0, 1));
        if (c) begin
          d[0] = $urandom_range(0, 9);
          d[1] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
          d[2] = $urandom_range(0, 5);
          d[3] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
        end else begin
          d[0] = $urandom_range(0, 7);
          d[1] = ($urandom_range(0, 15) == 0) ? 10 : $urandom_range(0, 9);
          d[2] = $urandom_range(0, 7);
          d[3] = $urandom_range(0, 9);
        end
      end
      pc = c;
      for (int i = 0; i < 4; i++) begin
        pd[i]   = d[i];
        an_s[i] = an_tab[i];
        sg_s[i] = seg_tab[d[i]];
        cl_s[i] = c;
        rs_s[i] = 1'b1;
      end
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 11))
        0: sg_s[k] = SEG_BAD;
        1: an_s[k] = AN_IDLE;
        2: an_s[k] = an_tab[$urandom_range(0, 3)];
        3: cl_s[k] = ~cl_s[k];
        4: an_s[k] = 4'b0011;
        5: rs_s[k] = 1'b0;
        default: ;
      endcase
      for (int i = 0; i < 4; i++) step(an_s[i], sg_s[i], cl_s[i], rs_s[i]);
      if ($urandom_range(0, 3) == 0) idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
